// File: rtl/spim_xip_arb.sv
// spim_xip_arb: shares the single register port of the SPI flash master
// between CPU register accesses and XIP word fetches.
//
// Each XIP fetch is turned into a fixed register program on the master:
//   write ADDR, write CMD (read), poll STAT until done, read 4 RX bytes,
//   write CMD (clear), then return the little-endian word.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cpu_valid/ready/addr/wdata/wstrb/rdata
//                           CPU register port (wstrb==0 means read)
//   xip_valid/ready/addr/rdata
//                           XIP word fetch port (xip_addr[1:0] ignored)
//   m_valid/ready/addr/wdata/wstrb/rdata
//                           master register port (registered request side)
//
// Optional feature: define SPIM_XIP_CACHE_EN for a one-entry fetch cache.
// Any completed CPU write invalidates it.
module spim_xip_arb #(
    parameter logic [11:0] ADDR_OFS = 12'h010,
    parameter logic [11:0] CMD_OFS  = 12'h00C,
    parameter logic [11:0] STAT_OFS = 12'h004,
    parameter logic [11:0] RXD_OFS  = 12'h01C,
    parameter logic [31:0] CMD_RD   = 32'h0003_0C06,
    parameter logic [31:0] CMD_CLR  = 32'h0000_0000,
    parameter int          DONE_BIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [11:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic [31:0] cpu_rdata,
    input  logic        xip_valid,
    output logic        xip_ready,
    input  logic [23:0] xip_addr,
    output logic [31:0] xip_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [11:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata
);

    typedef enum logic [2:0] {IDLE, CPU, X_ADDR, X_CMD, X_POLL, X_RXD, X_CLR, X_RESP} state_t;

    state_t      state, state_n;
    logic        m_valid_n;
    logic [11:0] m_addr_n;
    logic [31:0] m_wdata_n;
    logic [3:0]  m_wstrb_n;
    logic        cpu_ready_n, xip_ready_n;
    logic [31:0] cpu_rdata_n, xip_rdata_n;
    logic [23:2] a_r, a_n;
    logic [1:0]  bc, bc_n;
    logic [31:0] word, word_n;
    logic        last_xip, last_xip_n;
    logic        cpu_req, xip_req, grant_cpu, grant_xip;

    // Word aligned: the byte offset bits are intentionally dropped.
    logic unused_ok;
    assign unused_ok = &{1'b0, xip_addr[1:0]};

`ifdef SPIM_XIP_CACHE_EN
    logic [23:2] c_tag, c_tag_n;
    logic [31:0] c_data, c_data_n;
    logic        c_vld, c_vld_n;
    logic        c_hit;
    assign c_hit = c_vld && (c_tag == xip_addr[23:2]);
`endif

    // A requester whose ready is pulsing this cycle still shows valid; mask it
    // so the same request is not granted a second time.
    assign cpu_req   = cpu_valid && !cpu_ready;
    assign xip_req   = xip_valid && !xip_ready;
    assign grant_cpu = cpu_req && (!xip_req || last_xip);
    assign grant_xip = xip_req && !grant_cpu;

    always_comb begin
        state_n     = state;
        m_valid_n   = m_valid;
        m_addr_n    = m_addr;
        m_wdata_n   = m_wdata;
        m_wstrb_n   = m_wstrb;
        cpu_ready_n = 1'b0;
        cpu_rdata_n = cpu_rdata;
        xip_ready_n = 1'b0;
        xip_rdata_n = xip_rdata;
        a_n         = a_r;
        bc_n        = bc;
        word_n      = word;
        last_xip_n  = last_xip;
`ifdef SPIM_XIP_CACHE_EN
        c_tag_n     = c_tag;
        c_data_n    = c_data;
        c_vld_n     = c_vld;
`endif
        // In the sequence states m_valid is low on entry (it drops the cycle
        // after m_ready), which gives the mandatory idle cycle between accesses.
        case (state)
            IDLE: begin
                if (cpu_req && xip_req) last_xip_n = grant_xip;
                if (grant_cpu) begin
                    state_n   = CPU;
                    m_valid_n = 1'b1;
                    m_addr_n  = cpu_addr;
                    m_wdata_n = cpu_wdata;
                    m_wstrb_n = cpu_wstrb;
                end else if (grant_xip) begin
                    a_n     = xip_addr[23:2];
                    state_n = X_ADDR;
`ifdef SPIM_XIP_CACHE_EN
                    if (c_hit) begin
                        word_n  = c_data;
                        state_n = X_RESP;
                    end
`endif
                end
            end
            CPU: begin
                if (m_ready) begin
                    m_valid_n   = 1'b0;
                    cpu_ready_n = 1'b1;
                    cpu_rdata_n = m_rdata;
                    state_n     = IDLE;
`ifdef SPIM_XIP_CACHE_EN
                    if (m_wstrb != 4'h0) c_vld_n = 1'b0;
`endif
                end
            end
            X_ADDR: begin
                if (!m_valid) begin
                    m_valid_n = 1'b1;
                    m_addr_n  = ADDR_OFS;
                    m_wdata_n = {8'h00, a_r, 2'b00};
                    m_wstrb_n = 4'hF;
                end else if (m_ready) begin
                    m_valid_n = 1'b0;
                    state_n   = X_CMD;
                end
            end
            X_CMD: begin
                if (!m_valid) begin
                    m_valid_n = 1'b1;
                    m_addr_n  = CMD_OFS;
                    m_wdata_n = CMD_RD;
                    m_wstrb_n = 4'hF;
                end else if (m_ready) begin
                    m_valid_n = 1'b0;
                    state_n   = X_POLL;
                end
            end
            X_POLL: begin
                if (!m_valid) begin
                    m_valid_n = 1'b1;
                    m_addr_n  = STAT_OFS;
                    m_wdata_n = 32'h0;
                    m_wstrb_n = 4'h0;
                end else if (m_ready) begin
                    m_valid_n = 1'b0;
                    if (m_rdata[DONE_BIT]) begin
                        bc_n    = 2'd0;
                        state_n = X_RXD;
                    end
                end
            end
            X_RXD: begin
                if (!m_valid) begin
                    m_valid_n = 1'b1;
                    m_addr_n  = RXD_OFS;
                    m_wdata_n = 32'h0;
                    m_wstrb_n = 4'h0;
                end else if (m_ready) begin
                    m_valid_n                 = 1'b0;
                    word_n[{bc, 3'b000} +: 8] = m_rdata[7:0];
                    bc_n                      = bc + 2'd1;
                    if (bc == 2'd3) state_n = X_CLR;
                end
            end
            X_CLR: begin
                if (!m_valid) begin
                    m_valid_n = 1'b1;
                    m_addr_n  = CMD_OFS;
                    m_wdata_n = CMD_CLR;
                    m_wstrb_n = 4'hF;
                end else if (m_ready) begin
                    m_valid_n = 1'b0;
                    state_n   = X_RESP;
                end
            end
            X_RESP: begin
                xip_ready_n = 1'b1;
                xip_rdata_n = word;
                state_n     = IDLE;
`ifdef SPIM_XIP_CACHE_EN
                c_tag_n  = a_r;
                c_data_n = word;
                c_vld_n  = 1'b1;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            m_valid   <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            xip_ready <= 1'b0;
            xip_rdata <= '0;
            a_r       <= '0;
            bc        <= '0;
            word      <= '0;
            last_xip  <= 1'b1;
`ifdef SPIM_XIP_CACHE_EN
            c_tag     <= '0;
            c_data    <= '0;
            c_vld     <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            m_valid   <= m_valid_n;
            m_addr    <= m_addr_n;
            m_wdata   <= m_wdata_n;
            m_wstrb   <= m_wstrb_n;
            cpu_ready <= cpu_ready_n;
            cpu_rdata <= cpu_rdata_n;
            xip_ready <= xip_ready_n;
            xip_rdata <= xip_rdata_n;
            a_r       <= a_n;
            bc        <= bc_n;
            word      <= word_n;
            last_xip  <= last_xip_n;
`ifdef SPIM_XIP_CACHE_EN
            c_tag     <= c_tag_n;
            c_data    <= c_data_n;
            c_vld     <= c_vld_n;
`endif
        end
    end

endmodule

// File: tb/tb_spim_xip_arb.sv
// Testbench for spim_xip_arb: a behavioural SPI master register model sits on
// the m port; expected master accesses and CPU/XIP responses are queued when
// stimulus is issued and checked when the DUT produces them.
module tb_spim_xip_arb;

    localparam logic [11:0] ADDR_OFS = 12'h010;
    localparam logic [11:0] CMD_OFS  = 12'h00C;
    localparam logic [11:0] STAT_OFS = 12'h004;
    localparam logic [11:0] RXD_OFS  = 12'h01C;
    localparam logic [31:0] CMD_RD   = 32'h0003_0C06;
    localparam int LAT = 1;
    localparam int TMO = 3000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cpu_valid = 1'b0, cpu_ready;
    logic [11:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0, cpu_rdata;
    logic [3:0]  cpu_wstrb = '0;
    logic        xip_valid = 1'b0, xip_ready;
    logic [23:0] xip_addr = '0;
    logic [31:0] xip_rdata;
    logic        m_valid, m_ready = 1'b0;
    logic [11:0] m_addr;
    logic [31:0] m_wdata, m_rdata = '0;
    logic [3:0]  m_wstrb;

    always #5 clk = ~clk;

    spim_xip_arb dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
        .xip_valid(xip_valid), .xip_ready(xip_ready), .xip_addr(xip_addr),
        .xip_rdata(xip_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata)
    );

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } macc_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } vec_t;

    macc_t       exp_m[$];
    logic [31:0] exp_cpu[$], exp_xip[$];
    logic [7:0]  rx_q[$];
    int          polls_q[$];
    logic [31:0] regs[0:1023];

    int n_cmp = 0, n_err = 0;
    int poll_left = 0, stat_reads = 0, rxd_acks = 0, m_acks = 0, xip_rdy_cnt = 0;
    int wait_n = 0;
    bit busy = 1'b0;
    macc_t cap, e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Master model + response monitors, all on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_ready) begin
                chk("cpu_ready_lat", 32'(m_ready), 32'd1);
                if (exp_cpu.size() == 0) fail("cpu_ready_unexpected");
                else chk("cpu_rdata", cpu_rdata, exp_cpu.pop_front());
            end
            if (xip_ready) begin
                xip_rdy_cnt++;
                if (exp_xip.size() == 0) fail("xip_ready_unexpected");
                else chk("xip_rdata", xip_rdata, exp_xip.pop_front());
            end
        end
        if (!rst_n) begin
            m_ready = 1'b0;
            busy    = 1'b0;
        end else if (m_ready) begin
            m_ready = 1'b0;
            chk("m_valid_drop", 32'(m_valid), 32'd0);
        end else if (m_valid) begin
            if (!busy) begin
                busy   = 1'b1;
                wait_n = LAT;
                cap    = '{m_addr, m_wdata, m_wstrb};
            end else begin
                chk("m_addr_stable", 32'(m_addr), 32'(cap.addr));
                chk("m_wdata_stable", m_wdata, cap.wdata);
            end
            if (wait_n == 0) begin
                busy    = 1'b0;
                m_ready = 1'b1;
                m_rdata = 32'h0;
                m_acks++;
                if (exp_m.size() == 0) begin
                    $display("FAIL m_unexpected: addr %h wdata %h wstrb %h", cap.addr, cap.wdata, cap.wstrb);
                    n_cmp++;
                    n_err++;
                end else begin
                    e = exp_m.pop_front();
                    chk("m_addr", 32'(cap.addr), 32'(e.addr));
                    chk("m_wstrb", 32'(cap.wstrb), 32'(e.wstrb));
                    if (e.wstrb != 4'h0) chk("m_wdata", cap.wdata, e.wdata);
                end
                if (cap.wstrb != 4'h0) begin
                    if (cap.addr == ADDR_OFS) poll_left = (polls_q.size() != 0) ? polls_q.pop_front() : 0;
                    for (int b = 0; b < 4; b++)
                        if (cap.wstrb[b]) regs[cap.addr[11:2]][8*b +: 8] = cap.wdata[8*b +: 8];
                end else if (cap.addr == STAT_OFS) begin
                    stat_reads++;
                    if (poll_left > 0) begin
                        poll_left--;
                        m_rdata = 32'hFFFF_FFFE;
                    end else m_rdata = 32'h0000_0001;
                end else if (cap.addr == RXD_OFS) begin
                    rxd_acks++;
                    m_rdata = {24'hABCDEF, (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00};
                end else m_rdata = regs[cap.addr[11:2]];
            end else wait_n--;
        end
    end

    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    // Queue the full register program of one fetch plus its response.
    task automatic push_xip(input logic [23:0] a, input int polls, input logic [31:0] w);
        exp_m.push_back('{ADDR_OFS, {8'h00, a[23:2], 2'b00}, 4'hF});
        exp_m.push_back('{CMD_OFS, CMD_RD, 4'hF});
        for (int i = 0; i <= polls; i++) exp_m.push_back('{STAT_OFS, 32'h0, 4'h0});
        for (int i = 0; i < 4; i++) begin
            exp_m.push_back('{RXD_OFS, 32'h0, 4'h0});
            rx_q.push_back(w[8*i +: 8]);
        end
        exp_m.push_back('{CMD_OFS, 32'h0, 4'hF});
        polls_q.push_back(polls);
        exp_xip.push_back(w);
    endtask

    task automatic cpu_req(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int t;
        t = 0;
        @(negedge clk);
        cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; cpu_valid = 1'b1;
        do begin @(negedge clk); t++; end while (!cpu_ready && t < TMO);
        if (!cpu_ready) fail("cpu_timeout");
        cpu_valid = 1'b0;
    endtask

    task automatic xip_req(input logic [23:0] a);
        int t;
        t = 0;
        @(negedge clk);
        xip_addr = a; xip_valid = 1'b1;
        do begin @(negedge clk); t++; end while (!xip_ready && t < TMO);
        if (!xip_ready) fail("xip_timeout");
        xip_valid = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_addr"}, 32'(m_addr), 32'd0);
        chk({tag, "_m_wdata"}, m_wdata, 32'd0);
        chk({tag, "_m_wstrb"}, 32'(m_wstrb), 32'd0);
        chk({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_xip_ready"}, 32'(xip_ready), 32'd0);
        chk({tag, "_xip_rdata"}, xip_rdata, 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int base, t, rdy0;
        for (int i = 0; i < 1024; i++) regs[i] = 32'hC0DE_0000 | i;
        vecs[0] = '{12'h008, 32'h1234_5678, 4'hF, 32'h0};
        vecs[1] = '{12'h008, 32'hDEAD_BEEF, 4'h0, 32'h1234_5678};
        vecs[2] = '{12'h008, 32'hAABB_CCDD, 4'h5, 32'h0};
        vecs[3] = '{12'h008, 32'h0,         4'h0, 32'h12BB_56DD};
        vecs[4] = '{12'h020, 32'h0,         4'h0, 32'hC0DE_0008};
        vecs[5] = '{12'h014, 32'hCAFE_F00D, 4'hF, 32'h0};
        vecs[6] = '{12'h014, 32'h0,         4'h0, 32'hCAFE_F00D};

        // Reset state
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #2 rst_n = 1'b1;

        // CPU register accesses, XIP idle
        foreach (vecs[i]) begin
            exp_m.push_back('{vecs[i].addr, vecs[i].wdata, vecs[i].wstrb});
            exp_cpu.push_back(vecs[i].rdata);
            cpu_req(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
        end

        // Basic fetch: 3 not-done polls, bytes 11,22,33,44
        push_xip(24'h000103, 3, 32'h4433_2211);
        xip_req(24'h000103);

        // Collision from reset: CPU first, then XIP
        do_reset();
        exp_m.push_back('{12'h008, 32'h0000_00A1, 4'hF});
        exp_cpu.push_back(32'h0);
        push_xip(24'h000500, 0, 32'hA1A2_A3A4);
        fork
            cpu_req(12'h008, 32'h0000_00A1, 4'hF);
            xip_req(24'h000500);
        join
        // Repeated collision: XIP first this time
        push_xip(24'h000600, 1, 32'hB1B2_B3B4);
        exp_m.push_back('{12'h008, 32'h0000_00B2, 4'hF});
        exp_cpu.push_back(32'h0);
        fork
            cpu_req(12'h008, 32'h0000_00B2, 4'hF);
            xip_req(24'h000600);
        join

        // CPU request raised during polling waits until after the clear write
        push_xip(24'h000108, 3, 32'h8877_6655);
        exp_m.push_back('{12'h018, 32'h0BAD_F00D, 4'hF});
        exp_cpu.push_back(32'h0);
        base = stat_reads;
        fork
            xip_req(24'h000108);
            begin
                t = 0;
                while (stat_reads == base && t < TMO) begin @(negedge clk); t++; end
                cpu_req(12'h018, 32'h0BAD_F00D, 4'hF);
            end
        join

        // Reset while draining RX (bc=2): outputs cleared, no xip_ready
        push_xip(24'h000304, 0, 32'hDEAD_C0DE);
        base = rxd_acks;
        @(negedge clk);
        xip_addr = 24'h000304; xip_valid = 1'b1;
        t = 0;
        while (rxd_acks < base + 2 && t < TMO) begin @(negedge clk); t++; end
        if (rxd_acks < base + 2) fail("rxd_wait_timeout");
        rdy0 = xip_rdy_cnt;
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midrst");
        xip_valid = 1'b0;
        exp_m.delete(); exp_xip.delete(); rx_q.delete(); polls_q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_xip_ready", 32'(xip_rdy_cnt), 32'(rdy0));
        push_xip(24'h000404, 2, 32'h0F1E_2D3C);
        xip_req(24'h000404);

`ifdef SPIM_XIP_CACHE_EN
        // Cache: repeat hit has no master traffic; CPU write invalidates
        do_reset();
        push_xip(24'h000200, 1, 32'h5566_7788);
        xip_req(24'h000200);
        base = m_acks;
        exp_xip.push_back(32'h5566_7788);
        xip_req(24'h000200);
        chk("cache_hit_m_acks", 32'(m_acks - base), 32'd0);
        exp_m.push_back('{12'h008, 32'h0000_0001, 4'hF});
        exp_cpu.push_back(32'h0);
        cpu_req(12'h008, 32'h0000_0001, 4'hF);
        push_xip(24'h000200, 0, 32'h99AA_BBCC);
        xip_req(24'h000200);
`endif

        repeat (4) @(negedge clk);
        chk("exp_m_left", 32'(exp_m.size()), 32'd0);
        chk("exp_cpu_left", 32'(exp_cpu.size()), 32'd0);
        chk("exp_xip_left", 32'(exp_xip.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
